// File: rtl/sequencer_hs.sv
// -----------------------------------------------------------------------------
// sequencer_hs
// Multicycle control FSM for the accumulator CPU. It decodes the IR opcode and
// drives the datapath/memory strobes. Every memory access (instruction fetch
// read, operand read, store write) waits on a mem_ready handshake. The wait has
// a bounded timeout that traps into an error state.
//
// Parameters
//   OP_W      opcode width (>= 4). Defined codes have their upper bits zero.
//   WAIT_MAX  wait cycles allowed per access before the ERR trap. With 0, ready
//             is required in the first access cycle.
//
// Ports
//   clock       in   rising-edge clock
//   n_reset     in   synchronous active-low reset; forces all outputs to 0
//   op          in   IR opcode field (stable from FLD onward)
//   z_flag      in   accumulator zero flag, consulted in DEC only
//   mem_ready   in   memory completes the current CS access this cycle
//   ACC_bus, PC_bus, MDR_bus, Addr_bus            out  bus drive enables
//   load_ACC, load_PC, load_IR, load_MAR, load_MDR  out  register loads
//   ALU_ACC, ALU_add, ALU_sub, ALU_xor, ALU_and, ALU_or  out  ALU select/op
//   INC_PC      out  PC increment select
//   CS, R_NW    out  memory chip select; R_NW 1 = read, 0 = write
//   instr_done  out  one-cycle pulse in the cycle before returning to FETCH
//   halted      out  high in HLT
//   mem_err     out  high in ERR
//
// All strobes are combinational decodes of state, op and z_flag.
// -----------------------------------------------------------------------------
module sequencer_hs #(
  parameter int OP_W     = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic            clock,
  input  logic            n_reset,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  input  logic            mem_ready,
  output logic            ACC_bus,
  output logic            PC_bus,
  output logic            MDR_bus,
  output logic            Addr_bus,
  output logic            load_ACC,
  output logic            load_PC,
  output logic            load_IR,
  output logic            load_MAR,
  output logic            load_MDR,
  output logic            ALU_ACC,
  output logic            ALU_add,
  output logic            ALU_sub,
  output logic            ALU_xor,
  output logic            ALU_and,
  output logic            ALU_or,
  output logic            INC_PC,
  output logic            CS,
  output logic            R_NW,
  output logic            instr_done,
  output logic            halted,
  output logic            mem_err
);

  // The wait counter must be able to hold WAIT_MAX. It is at least one bit wide.
  localparam int CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Opcodes are compared at full width, so junk in the upper bits is undefined.
  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_JMP   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(9);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(15);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0,
    S_FRD   = 4'd1,
    S_FLD   = 4'd2,
    S_DEC   = 4'd3,
    S_STM   = 4'd4,
    S_SWR   = 4'd5,
    S_ROP   = 4'd6,
    S_EXL   = 4'd7,
    S_EXA   = 4'd8,
    S_EXB   = 4'd9,
    S_HLT   = 4'd10,
    S_ERR   = 4'd11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic is_alu_s;
  logic is_branch_s;
  logic branch_taken_s;
  logic wait_timeout_s;

  // Opcode class decode shared by DEC and ROP.
  always_comb begin
    is_alu_s    = 1'b0;
    is_branch_s = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR: is_alu_s    = 1'b1;
      OP_BNE, OP_BEQ:                        is_branch_s = 1'b1;
      default:                               is_alu_s    = 1'b0;
    endcase
    branch_taken_s = ((op == OP_BNE) && !z_flag) || ((op == OP_BEQ) && z_flag);
    // The counter never exceeds the limit, so equality is the timeout point.
    wait_timeout_s = (wait_cnt_q == WAIT_LIMIT);
  end

  // Next-state, wait counter and strobe decode. While reset is asserted, all
  // strobes keep their zero defaults.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = CNT_ZERO;   // cleared on every exit from a memory state
    ACC_bus    = 1'b0;
    PC_bus     = 1'b0;
    MDR_bus    = 1'b0;
    Addr_bus   = 1'b0;
    load_ACC   = 1'b0;
    load_PC    = 1'b0;
    load_IR    = 1'b0;
    load_MAR   = 1'b0;
    load_MDR   = 1'b0;
    ALU_ACC    = 1'b0;
    ALU_add    = 1'b0;
    ALU_sub    = 1'b0;
    ALU_xor    = 1'b0;
    ALU_and    = 1'b0;
    ALU_or     = 1'b0;
    INC_PC     = 1'b0;
    CS         = 1'b0;
    R_NW       = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    mem_err    = 1'b0;

    if (n_reset) begin
      case (state_q)
        S_FETCH: begin
          PC_bus   = 1'b1;
          load_MAR = 1'b1;
          INC_PC   = 1'b1;
          load_PC  = 1'b1;
          state_d  = S_FRD;
        end

        S_FRD: begin
          CS   = 1'b1;
          R_NW = 1'b1;
          if (mem_ready) begin
            state_d = S_FLD;
          end else if (wait_timeout_s) begin
            state_d = S_ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_ONE;
          end
        end

        S_FLD: begin
          MDR_bus = 1'b1;
          load_IR = 1'b1;
          state_d = S_DEC;
        end

        S_DEC: begin
          case (op)
            OP_HALT: begin
              state_d = S_HLT;
            end
            OP_JMP: begin
              // Direct jump: the address field goes straight into the PC.
              Addr_bus   = 1'b1;
              load_PC    = 1'b1;
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end
            default: begin
              Addr_bus = 1'b1;
              load_MAR = 1'b1;
              if (op == OP_STORE) begin
                state_d = S_STM;
              end else if ((op == OP_LOAD) || is_alu_s || branch_taken_s) begin
                state_d = S_ROP;
              end else begin
                // Branch not taken or undefined opcode: retire as a NOP.
                instr_done = 1'b1;
                state_d    = S_FETCH;
              end
            end
          endcase
        end

        S_STM: begin
          ACC_bus  = 1'b1;
          load_MDR = 1'b1;
          state_d  = S_SWR;
        end

        S_SWR: begin
          CS = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else if (wait_timeout_s) begin
            state_d = S_ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_ONE;
          end
        end

        S_ROP: begin
          CS   = 1'b1;
          R_NW = 1'b1;
          if (mem_ready) begin
            if (op == OP_LOAD) begin
              state_d = S_EXL;
            end else if (is_branch_s) begin
              state_d = S_EXB;
            end else if (is_alu_s) begin
              state_d = S_EXA;
            end else begin
              // The IR changed under an operand read; trap instead of guessing.
              state_d = S_ERR;
            end
          end else if (wait_timeout_s) begin
            state_d = S_ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_ONE;
          end
        end

        S_EXL: begin
          MDR_bus    = 1'b1;
          load_ACC   = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end

        S_EXA: begin
          MDR_bus    = 1'b1;
          ALU_ACC    = 1'b1;
          load_ACC   = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
          case (op)
            OP_ADD:  ALU_add = 1'b1;
            OP_SUB:  ALU_sub = 1'b1;
            OP_XOR:  ALU_xor = 1'b1;
            OP_AND:  ALU_and = 1'b1;
            OP_OR:   ALU_or  = 1'b1;
            default: ALU_add = 1'b0;
          endcase
        end

        S_EXB: begin
          // Indirect branch: the operand read from memory is the new PC.
          MDR_bus    = 1'b1;
          load_PC    = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end

        S_HLT: begin
          halted  = 1'b1;
          state_d = S_HLT;
        end

        S_ERR: begin
          mem_err = 1'b1;
          state_d = S_ERR;
        end

        default: begin
          // Unused encodings fall into the error trap.
          state_d = S_ERR;
        end
      endcase
    end else begin
      state_d = S_FETCH;
    end
  end

  // State and wait-counter registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= CNT_ZERO;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule
